// File: rtl/exe_stage_unit.sv
// Execute stage: Val2 shifter, ALU, NZCV status register and EX/MEM register.
// Branch target and taken flag are combinational; everything else is registered.
module exe_stage_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] reg1_in,
    input  logic [DATA_W-1:0] reg2_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              wb_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic              imm_in,
    input  logic              carry_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       imm24_in,
    input  logic [3:0]        dest_in,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] store_val_out,
    output logic [3:0]        dest_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              wb_en_out,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic [3:0]        status_out
);

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] a);
        return (x >> a) | (x << (6'd32 - {1'b0, a}));
    endfunction

    logic [31:0] val2;
    logic [4:0]  sh_amt;
    logic [4:0]  rot_amt;

    always_comb begin
        sh_amt  = shift_operand_in[11:7];
        rot_amt = {shift_operand_in[11:8], 1'b0};
        val2    = reg2_in;
        if (imm_in) begin
            val2 = ror32({24'b0, shift_operand_in[7:0]}, rot_amt);
        end else if (mem_read_in | mem_write_in) begin
            val2 = {20'b0, shift_operand_in};
        end else begin
            unique case (shift_operand_in[6:5])
                2'b00:   val2 = reg2_in << sh_amt;
                2'b01:   val2 = reg2_in >> sh_amt;
                2'b10:   val2 = $signed(reg2_in) >>> sh_amt;
                default: val2 = ror32(reg2_in, sh_amt);
            endcase
        end
    end

    logic [3:0]  status_q, status_d;
    logic [32:0] sum;
    logic [31:0] res;
    logic        flag_n, flag_z, flag_c, flag_v;

    // Logical/move ops keep C and V from the current status register.
    always_comb begin
        sum    = '0;
        res    = '0;
        flag_c = status_q[1];
        flag_v = status_q[0];
        case (exe_cmd_in)
            4'b0001: res = val2;
            4'b1001: res = ~val2;
            4'b0010, 4'b0011: begin
                sum    = {1'b0, reg1_in} + {1'b0, val2}
                       + {32'b0, exe_cmd_in[0] & carry_in};
                res    = sum[31:0];
                flag_c = sum[32];
                flag_v = (reg1_in[31] == val2[31]) && (res[31] != reg1_in[31]);
            end
            4'b0100, 4'b0101: begin
                sum    = {1'b0, reg1_in} + {1'b0, ~val2}
                       + {32'b0, exe_cmd_in[0] ? carry_in : 1'b1};
                res    = sum[31:0];
                flag_c = sum[32];
                flag_v = (reg1_in[31] != val2[31]) && (res[31] != reg1_in[31]);
            end
            4'b0110: res = reg1_in & val2;
            4'b0111: res = reg1_in | val2;
            4'b1000: res = reg1_in ^ val2;
            default: res = '0;
        endcase
        flag_n = res[31];
        flag_z = (res == 32'b0);
    end

    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] store_val_q, store_val_d;
    logic [3:0]  dest_q, dest_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        wb_en_q, wb_en_d;

    always_comb begin
        alu_result_d = res;
        store_val_d  = reg2_in;
        dest_d       = dest_in;
        mem_read_d   = mem_read_in;
        mem_write_d  = mem_write_in;
        wb_en_d      = wb_en_in;
        status_d     = s_in ? {flag_n, flag_z, flag_c, flag_v} : status_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q <= '0;
            store_val_q  <= '0;
            dest_q       <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            wb_en_q      <= 1'b0;
            status_q     <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            store_val_q  <= store_val_d;
            dest_q       <= dest_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            wb_en_q      <= wb_en_d;
            status_q     <= status_d;
        end
    end

    assign alu_result_out = alu_result_q;
    assign store_val_out  = store_val_q;
    assign dest_out       = dest_q;
    assign mem_read_out   = mem_read_q;
    assign mem_write_out  = mem_write_q;
    assign wb_en_out      = wb_en_q;
    assign status_out     = status_q;
    assign branch_taken   = b_in;
    assign branch_addr    = pc_in + {{6{imm24_in[23]}}, imm24_in, 2'b00};

endmodule

// File: tb/tb_exe_stage_unit.sv
// Scoreboard bench for exe_stage_unit: directed vectors push expectations,
// a monitor pops and compares one entry after each capturing edge.
module tb_exe_stage_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, reg1_in, reg2_in;
    logic [3:0]  exe_cmd_in;
    logic        mem_read_in, mem_write_in, wb_en_in, b_in, s_in;
    logic        imm_in, carry_in;
    logic [11:0] shift_operand_in;
    logic [23:0] imm24_in;
    logic [3:0]  dest_in;
    logic [31:0] alu_result_out, store_val_out, branch_addr;
    logic [3:0]  dest_out, status_out;
    logic        mem_read_out, mem_write_out, wb_en_out, branch_taken;

    exe_stage_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in),
        .reg1_in(reg1_in), .reg2_in(reg2_in),
        .exe_cmd_in(exe_cmd_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .wb_en_in(wb_en_in),
        .b_in(b_in), .s_in(s_in), .imm_in(imm_in),
        .carry_in(carry_in), .shift_operand_in(shift_operand_in),
        .imm24_in(imm24_in), .dest_in(dest_in),
        .alu_result_out(alu_result_out), .store_val_out(store_val_out),
        .dest_out(dest_out), .mem_read_out(mem_read_out),
        .mem_write_out(mem_write_out), .wb_en_out(wb_en_out),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .status_out(status_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] st;
        logic [3:0]  dest;
        logic        mr, mw, wb;
        logic [3:0]  status;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  vec_id = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic [3:0] cmd, input logic imm, input logic [11:0] so,
                       input logic [31:0] rn, input logic [31:0] rm,
                       input logic mr, input logic mw, input logic wb,
                       input logic s, input logic cin,
                       input logic [31:0] exp_alu, input logic [3:0] exp_st);
        exp_t e;
        @(negedge clk);
        exe_cmd_in = cmd; imm_in = imm; shift_operand_in = so;
        reg1_in = rn; reg2_in = rm; mem_read_in = mr; mem_write_in = mw;
        wb_en_in = wb; s_in = s; carry_in = cin; b_in = 1'b0;
        dest_in = vec_id;
        e.alu = exp_alu; e.st = rm; e.dest = vec_id;
        e.mr = mr; e.mw = mw; e.wb = wb; e.status = exp_st;
        sb_q.push_back(e);
        vec_id = vec_id + 4'd1;
    endtask

    task automatic brn(input logic [31:0] pc, input logic [23:0] off, input logic [31:0] exp_addr);
        pc_in = pc; imm24_in = off; b_in = 1'b1;
        #1;
        chk("branch_addr", branch_addr, exp_addr);
        chk("branch_taken", {31'b0, branch_taken}, 32'd1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("alu_result", alu_result_out, e.alu);
                chk("store_val", store_val_out, e.st);
                chk("dest", {28'b0, dest_out}, {28'b0, e.dest});
                chk("ctrl", {29'b0, mem_read_out, mem_write_out, wb_en_out},
                    {29'b0, e.mr, e.mw, e.wb});
                chk("status", {28'b0, status_out}, {28'b0, e.status});
            end
        end
    end

    initial begin : stim
        rst = 1'b1; pc_in = '0; reg1_in = '0; reg2_in = '0;
        exe_cmd_in = '0; mem_read_in = 0; mem_write_in = 0; wb_en_in = 0;
        b_in = 0; s_in = 0; imm_in = 0; carry_in = 0;
        shift_operand_in = '0; imm24_in = '0; dest_in = '0;
        #2;
        chk("reset_alu", alu_result_out, 32'd0);
        chk("reset_status", {28'b0, status_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // MOV rotated immediate, ASR, ROR
        drv(4'b0001, 1, 12'h4FF, 32'h0, 32'h0, 0, 0, 1, 1, 0, 32'hFF000000, 4'b1000);
        drv(4'b0001, 0, 12'h240, 32'h0, 32'h80000000, 0, 0, 1, 0, 0, 32'hF8000000, 4'b1000);
        drv(4'b0001, 0, 12'h0E0, 32'h0, 32'h00000001, 0, 0, 1, 0, 0, 32'h80000000, 4'b1000);
        // SUB zero, ADD overflow
        drv(4'b0100, 1, 12'h005, 32'h5, 32'h0, 0, 0, 0, 1, 0, 32'h0, 4'b0110);
        drv(4'b0010, 1, 12'h001, 32'h7FFFFFFF, 32'h0, 0, 0, 1, 1, 0, 32'h80000000, 4'b1001);
        // LDR / STR address generation
        drv(4'b0010, 0, 12'h004, 32'h100, 32'hDEADBEEF, 1, 0, 1, 0, 0, 32'h104, 4'b1001);
        drv(4'b0010, 0, 12'hFFC, 32'h1000, 32'h12345678, 0, 1, 0, 0, 0, 32'h1FFC, 4'b1001);
        // branches: s=0 holds status, s=1 with unknown opcode updates N/Z only
        drv(4'b0000, 0, 12'h000, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 4'b1001);
        brn(32'h20, 24'hFFFFFE, 32'h18);
        drv(4'b0000, 0, 12'h000, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 4'b0101);
        brn(32'h100, 24'h000004, 32'h110);
        // ADC carry out, logical ops keep C/V
        drv(4'b0011, 1, 12'h000, 32'hFFFFFFFF, 32'h0, 0, 0, 1, 1, 1, 32'h0, 4'b0110);
        drv(4'b0110, 0, 12'h000, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 1, 1, 0, 32'hF000F000, 4'b1010);
        drv(4'b1001, 1, 12'h000, 32'h0, 32'h0, 0, 0, 1, 1, 0, 32'hFFFFFFFF, 4'b1010);
        drv(4'b1000, 0, 12'hFA0, 32'h3, 32'h80000000, 0, 0, 1, 0, 0, 32'h2, 4'b1010);
        // SBC borrow, ORR, SUB signed overflow
        drv(4'b0101, 1, 12'h005, 32'h5, 32'h0, 0, 0, 1, 1, 0, 32'hFFFFFFFF, 4'b1000);
        drv(4'b0111, 1, 12'h0FF, 32'h0000F000, 32'h0, 0, 0, 1, 0, 0, 32'h0000F0FF, 4'b1000);
        drv(4'b0100, 1, 12'h001, 32'h80000000, 32'h0, 0, 0, 1, 1, 0, 32'h7FFFFFFF, 4'b0011);

        // asynchronous reset mid-cycle wipes the in-flight result
        @(posedge clk);
        #3;
        chk("sb_drained", sb_q.size(), 32'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_alu", alu_result_out, 32'd0);
        chk("async_rst_store", store_val_out, 32'd0);
        chk("async_rst_dest", {28'b0, dest_out}, 32'd0);
        chk("async_rst_ctrl", {29'b0, mem_read_out, mem_write_out, wb_en_out}, 32'd0);
        chk("async_rst_status", {28'b0, status_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exe_stage_unit.md
Name: exe_stage_unit

Overview:
- Execute stage of the 5-stage ARM pipeline. Sits directly downstream of the ID/EX pipeline register and feeds the MEM stage.
- Builds the second ALU operand (Val2) from the immediate, shift or offset field, runs the ALU and computes the branch target.
- Holds the NZCV status register.
- Registers its results into the EX/MEM boundary, so MEM sees them one cycle later.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- pc_in  in  32  PC+4 of the instruction.
- reg1_in  in  32  Rn value.
- reg2_in  in  32  Rm value; also the store data.
- exe_cmd_in  in  4  ALU opcode.
- mem_read_in, mem_write_in, wb_en_in, b_in, s_in  in  1 each  control bits.
- imm_in  in  1  I bit.
- carry_in  in  1  C flag captured with the instruction.
- shift_operand_in  in  12  shifter operand field.
- imm24_in  in  24  signed branch offset.
- dest_in  in  4  destination register.
- alu_result_out  out  32  registered ALU result or address.
- store_val_out  out  32  registered reg2_in.
- dest_out  out  4  registered dest.
- mem_read_out, mem_write_out, wb_en_out  out  1 each  registered controls.
- branch_taken  out  1  combinational, equals b_in.
- branch_addr  out  32  combinational branch target.
- status_out  out  4  NZCV register, bit 3 = N.

Behaviour:
- Reset: all registered outputs are 0 and the status register is 0, asynchronously.
- Pipeline register: on each posedge, alu_result, store_val, dest, mem_read, mem_write and wb_en capture their next values. Latency is 1 cycle. There is no stall or flush input.
- Val2 selection, evaluated in this priority order:
  - imm_in=1: zero-extend shift_operand[7:0] to 32 bits, then rotate right by 2*shift_operand[11:8].
  - else mem_read_in|mem_write_in: zero-extend shift_operand[11:0].
  - else: shift reg2_in by shift_operand[11:7] with type shift_operand[6:5]. Types: 00 LSL, 01 LSR (zero fill), 10 ASR, 11 ROR. Shift amount 0 passes reg2_in unchanged for every type.
- ALU opcodes (exe_cmd_in):
  - 0001 MOV: Val2.
  - 1001 MVN: ~Val2.
  - 0010 ADD: Rn+Val2.
  - 0011 ADC: Rn+Val2+carry_in.
  - 0100 SUB: Rn+~Val2+1.
  - 0101 SBC: Rn+~Val2+carry_in.
  - 0110 AND, 0111 ORR, 1000 EOR.
  - Any other code: result 0 and the flags N and Z are derived from that 0.
  - CMP and TST arrive as SUB and AND with wb_en_in=0. LDR and STR arrive as ADD.
- Flags:
  - N = result[31]; Z = (result==0).
  - Arithmetic ops compute a 33-bit sum. C = bit 32, meaning SUB sets C=1 when there is no borrow.
  - V: for ADD/ADC, operands of equal sign and a result of different sign. For SUB/SBC, operands of differing sign and a result sign different from Rn.
  - Logical and move ops leave C and V unchanged.
- Status register: loads {N,Z,C,V} at posedge when s_in=1, otherwise holds. The update is visible on status_out from the following cycle.
- Branch: branch_addr = pc_in + (sign-extended imm24_in << 2), with 32-bit wrap. branch_taken = b_in. Both are combinational and not registered.
- Simultaneous events:
  - b_in=1 with s_in=1: the status register still updates.
  - reset asserted mid-operation: clears the outputs and the status register immediately. An in-flight result is lost.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all registered outputs and status_out are 0 before the next edge.
- Immediate rotate: imm=1, shift_operand=12'h4FF, MOV -> next cycle alu_result=32'hFF000000. With s_in=1, status_out becomes 4'b1000 the cycle after.
- Register shift: reg2=32'h80000000, shift_operand = amount 4, type ASR, MOV -> alu_result=32'hF8000000. Repeat with ROR by 1 on 32'h00000001 -> 32'h80000000.
- SUB flags: Rn=5, Val2=5, s_in=1 -> result 0, status_out=4'b0110. Then Rn=32'h7FFFFFFF ADD 1 with s_in=1 -> 32'h80000000, status_out=4'b1001.
- Memory address: mem_read=1, Rn=32'h100, shift_operand=12'h004, ADD -> alu_result=32'h104. imm and shift fields are ignored; store_val_out equals reg2_in.
- Branch: pc_in=32'h20, imm24=24'hFFFFFE, b_in=1 -> same cycle branch_addr=32'h18, branch_taken=1. status_out is unchanged when s_in=0.
